// File: rtl/hazard_fwd_scoreboard.sv
// hazard_fwd_scoreboard
//   Hazard and forwarding controller for the 5-stage pipeline. It keeps one
//   write record each for the E, M and W stages, together with a Tnew
//   countdown, and it runs the multi-cycle MDU busy counter. From these it
//   produces the global stall and the forward-mux selects for the D-stage
//   and E-stage read ports.
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   d_waddr/d_wsrc/d_tnew destination, result source and Tnew of the D instr
//   d_raddr/d_tuse        per-port read address and Tuse (Tuse 3 = port unused)
//   d_md_use              D instr touches HI/LO or the MDU
//   e_md_start/e_md_div   E instr starts the MDU (div when e_md_div=1)
//   stall                 hold PC and D, bubble into E
//   fwd_d_sel/fwd_e_sel   3-bit forward select per port (0 GRF/pipe reg,
//                         1 M_ALU, 2 M_PC, 3 W_ALU, 4 W_DM, 5 W_PC)
//   md_busy               MDU counter nonzero

// Per-read-port hazard and select logic for one lane.
module hfs_port #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] d_raddr,
    input  logic [1:0]        d_tuse,
    input  logic [REG_AW-1:0] e_raddr,
    input  logic              e_valid,
    input  logic [REG_AW-1:0] e_waddr,
    input  logic [1:0]        e_tnew,
    input  logic              m_valid,
    input  logic [REG_AW-1:0] m_waddr,
    input  logic [1:0]        m_wsrc,
    input  logic [1:0]        m_tnew,
    input  logic              w_valid,
    input  logic [REG_AW-1:0] w_waddr,
    input  logic [1:0]        w_wsrc,
    output logic              stall_req,
    output logic [2:0]        d_sel,
    output logic [2:0]        e_sel
);
    logic       e_hit_d, m_hit_d, w_hit_d, m_hit_e, w_hit_e;
    logic [1:0] e_tnew_eff;
    logic [2:0] m_sel, w_sel;

    // Records are valid only for nonzero destinations, so a hit never
    // happens on register 0.
    assign e_hit_d = e_valid && (e_waddr == d_raddr) && (d_raddr != '0);
    assign m_hit_d = m_valid && (m_waddr == d_raddr) && (d_raddr != '0);
    assign w_hit_d = w_valid && (w_waddr == d_raddr) && (d_raddr != '0);
    assign m_hit_e = m_valid && (m_waddr == e_raddr) && (e_raddr != '0);
    assign w_hit_e = w_valid && (w_waddr == e_raddr) && (e_raddr != '0);

    // E never forwards: even a Tnew=0 (PC) result must wait one cycle.
    assign e_tnew_eff = (e_tnew == 2'd0) ? 2'd1 : e_tnew;

    assign m_sel = (m_wsrc == 2'd2) ? 3'd2 : 3'd1;
    assign w_sel = (w_wsrc == 2'd1) ? 3'd4 : (w_wsrc == 2'd2) ? 3'd5 : 3'd3;

    assign stall_req = (d_tuse != 2'd3) &&
                       ((e_hit_d && (e_tnew_eff > d_tuse)) ||
                        (m_hit_d && (m_tnew > d_tuse)));

    always_comb begin
        d_sel = 3'd0;
        if (m_hit_d && (m_tnew == 2'd0)) d_sel = m_sel;
        else if (w_hit_d)                d_sel = w_sel;
    end

    // An M hit that is not ready yet cannot reach E (it stalled in D);
    // select the pipe register rather than an older W value.
    always_comb begin
        e_sel = 3'd0;
        if (m_hit_e)      e_sel = (m_tnew == 2'd0) ? m_sel : 3'd0;
        else if (w_hit_e) e_sel = w_sel;
    end
endmodule

module hazard_fwd_scoreboard #(
    parameter int NUM_RD   = 2,
    parameter int REG_AW   = 5,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [REG_AW-1:0]        d_waddr,
    input  logic [1:0]               d_wsrc,
    input  logic [1:0]               d_tnew,
    input  logic [NUM_RD*REG_AW-1:0] d_raddr,
    input  logic [NUM_RD*2-1:0]      d_tuse,
    input  logic                     d_md_use,
    input  logic                     e_md_start,
    input  logic                     e_md_div,
    output logic                     stall,
    output logic [NUM_RD*3-1:0]      fwd_d_sel,
    output logic [NUM_RD*3-1:0]      fwd_e_sel,
    output logic                     md_busy
);
    localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] waddr;
        logic [1:0]        wsrc;
        logic [1:0]        tnew;
    } rec_t;

    // W treats Tnew as 0, so it carries no countdown.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] waddr;
        logic [1:0]        wsrc;
    } wrec_t;

    rec_t                          e_rec, m_rec;
    wrec_t                         w_rec;
    logic [NUM_RD-1:0][REG_AW-1:0] e_raddr;
    logic [CW-1:0]                 md_cnt;
    logic [NUM_RD-1:0]             port_stall;

    assign md_busy = (md_cnt != '0);
    assign stall   = (|port_stall) || (d_md_use && (md_busy || e_md_start));

    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_port
            hfs_port #(.REG_AW(REG_AW)) u_port (
                .d_raddr   (d_raddr[p*REG_AW +: REG_AW]),
                .d_tuse    (d_tuse[p*2 +: 2]),
                .e_raddr   (e_raddr[p]),
                .e_valid   (e_rec.valid),
                .e_waddr   (e_rec.waddr),
                .e_tnew    (e_rec.tnew),
                .m_valid   (m_rec.valid),
                .m_waddr   (m_rec.waddr),
                .m_wsrc    (m_rec.wsrc),
                .m_tnew    (m_rec.tnew),
                .w_valid   (w_rec.valid),
                .w_waddr   (w_rec.waddr),
                .w_wsrc    (w_rec.wsrc),
                .stall_req (port_stall[p]),
                .d_sel     (fwd_d_sel[p*3 +: 3]),
                .e_sel     (fwd_e_sel[p*3 +: 3])
            );
        end
    endgenerate

    // Records always advance; stall only turns the D->E move into a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_rec   <= '0;
            m_rec   <= '0;
            w_rec   <= '0;
            e_raddr <= '0;
        end else begin
            w_rec <= '{valid: m_rec.valid, waddr: m_rec.waddr, wsrc: m_rec.wsrc};
            m_rec <= '{valid: e_rec.valid, waddr: e_rec.waddr, wsrc: e_rec.wsrc,
                       tnew: (e_rec.tnew == 2'd0) ? 2'd0 : e_rec.tnew - 2'd1};
            if (stall) begin
                e_rec   <= '0;
                e_raddr <= '0;
            end else begin
                e_rec.valid <= (d_waddr != '0);
                e_rec.waddr <= d_waddr;
                e_rec.wsrc  <= (d_wsrc == 2'd3) ? 2'd0 : d_wsrc; // illegal -> ALU
                e_rec.tnew  <= d_tnew;
                e_raddr     <= d_raddr;
            end
        end
    end

    // A start while busy is not legal, so it is simply not honoured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   md_cnt <= '0;
        else if (e_md_start && !md_busy) md_cnt <= e_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        else if (md_busy)               md_cnt <= md_cnt - 1'b1;
    end
endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
module tb_hazard_fwd_scoreboard;
    localparam int NR = 2;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [AW-1:0]   d_waddr = '0;
    logic [1:0]      d_wsrc = '0;
    logic [1:0]      d_tnew = 2'd1;
    logic [NR*AW-1:0] d_raddr = '0;
    logic [NR*2-1:0] d_tuse = '1;
    logic            d_md_use = 1'b0;
    logic            e_md_start = 1'b0;
    logic            e_md_div = 1'b0;
    logic            stall, md_busy;
    logic [NR*3-1:0] fwd_d_sel, fwd_e_sel;

    int tests_run = 0;
    int tests_failed = 0;

    hazard_fwd_scoreboard #(.NUM_RD(NR), .REG_AW(AW), .MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset_n(reset_n),
        .d_waddr(d_waddr), .d_wsrc(d_wsrc), .d_tnew(d_tnew),
        .d_raddr(d_raddr), .d_tuse(d_tuse), .d_md_use(d_md_use),
        .e_md_start(e_md_start), .e_md_div(e_md_div),
        .stall(stall), .fwd_d_sel(fwd_d_sel), .fwd_e_sel(fwd_e_sel),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // In-flight instructions are kept as a list with an age counted in edges
    // since entering E (0 = E, 1 = M, 2 = W). The MDU is modelled as the
    // cycle number at which it stops being busy.
    typedef struct {
        logic [AW-1:0]    waddr;
        logic [1:0]       wsrc;
        int               tnew0;
        logic [NR*AW-1:0] ra;
        int               age;
    } ins_t;

    ins_t pipe[$];
    int   cyc = 0;
    int   busy_end = 0;
    logic exp_stall, exp_busy;
    logic [NR*3-1:0] exp_fd, exp_fe;

    function automatic int wb_sel(logic [1:0] ws);
        return (ws == 2'd1) ? 4 : (ws == 2'd2) ? 5 : 3;
    endfunction

    // Newest ready producer wins; a not-yet-ready M producer blocks E ports.
    function automatic int sel_from(logic [AW-1:0] ra, bit is_e);
        if (ra == 0) return 0;
        for (int st = 1; st <= 2; st++)
            foreach (pipe[i])
                if (pipe[i].age == st && pipe[i].waddr == ra) begin
                    if (st == 1) begin
                        if (pipe[i].tnew0 - 1 <= 0) return (pipe[i].wsrc == 2'd2) ? 2 : 1;
                        if (is_e) return 0;
                    end else return wb_sel(pipe[i].wsrc);
                end
        return 0;
    endfunction

    task automatic model_eval();
        logic [AW-1:0] ra, era;
        int tu, tcur;
        exp_busy  = (cyc < busy_end);
        exp_stall = d_md_use && (exp_busy || e_md_start);
        for (int p = 0; p < NR; p++) begin
            ra  = d_raddr[p*AW +: AW];
            tu  = int'(d_tuse[p*2 +: 2]);
            era = '0;
            foreach (pipe[i]) begin
                if (pipe[i].age == 0) era = pipe[i].ra[p*AW +: AW];
                if (ra != 0 && tu != 3 && pipe[i].waddr == ra) begin
                    tcur = pipe[i].tnew0 - pipe[i].age;
                    if (tcur < 0) tcur = 0;
                    if (pipe[i].age == 0 && ((pipe[i].tnew0 < 1) ? 1 : pipe[i].tnew0) > tu) exp_stall = 1'b1;
                    if (pipe[i].age == 1 && tcur > tu) exp_stall = 1'b1;
                end
            end
            exp_fd[p*3 +: 3] = 3'(sel_from(ra, 1'b0));
            exp_fe[p*3 +: 3] = 3'(sel_from(era, 1'b1));
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        cyc = 0;
        busy_end = 0;
    endtask

    task automatic model_edge();
        ins_t n;
        model_eval();
        foreach (pipe[i]) pipe[i].age++;
        while (pipe.size() > 0 && pipe[0].age > 2) void'(pipe.pop_front());
        if (!exp_stall) begin
            n.waddr = d_waddr; n.wsrc = d_wsrc; n.tnew0 = int'(d_tnew);
            n.ra = d_raddr; n.age = 0;
            pipe.push_back(n);
        end
        if (e_md_start && !exp_busy) busy_end = cyc + 1 + (e_md_div ? 10 : 5);
        cyc++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic adv();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_d(input int wa, input int ws, input int tn,
                         input int r0, input int t0, input int r1, input int t1,
                         input bit mdu);
        d_waddr = AW'(wa); d_wsrc = 2'(ws); d_tnew = 2'(tn);
        d_raddr = {AW'(r1), AW'(r0)};
        d_tuse  = {2'(t1), 2'(t0)};
        d_md_use = mdu;
    endtask

    task automatic nop();
        set_d(0, 0, 1, 0, 3, 0, 3, 1'b0);
        e_md_start = 1'b0;
        e_md_div = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        nop();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        nop();
        reset_n = 1'b0;
        model_reset();
        #2;
        tests_run++;
        if ({stall, md_busy, fwd_d_sel, fwd_e_sel} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got stall=%b busy=%b d=%h e=%h want all 0", stall, md_busy, fwd_d_sel, fwd_e_sel);
        end
        // Only the D inputs themselves can raise stall while in reset.
        d_md_use = 1'b1; e_md_start = 1'b1; #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_md_stall: got %b want 1", stall);
        end
        nop();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_lw_beq();
        do_reset();
        set_d(1, 1, 2, 0, 3, 0, 3, 1'b0);
        adv();
        set_d(0, 0, 1, 1, 0, 0, 3, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests_run++;
            if (stall !== 1'b1) begin
                tests_failed++;
                $display("FAIL lw_beq_stall%0d: got %b want 1", k, stall);
            end
            adv();
        end
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || fwd_d_sel[2:0] !== 3'd4) begin
            tests_failed++;
            $display("FAIL lw_beq_fwd: got stall=%b sel=%0d want stall=0 sel=4", stall, fwd_d_sel[2:0]);
        end
        adv();
    endtask

    task automatic test_lw_addu();
        do_reset();
        set_d(1, 1, 2, 0, 3, 0, 3, 1'b0);
        adv();
        set_d(2, 0, 1, 1, 1, 3, 1, 1'b0);
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL lw_addu_e_stall: got %b want 1", stall);
        end
        adv();
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_addu_m_nostall: got %b want 0", stall);
        end
        adv();
        nop();
        @(negedge clk);
        tests_run++;
        if (fwd_e_sel[2:0] !== 3'd4 || fwd_e_sel[5:3] !== 3'd0) begin
            tests_failed++;
            $display("FAIL lw_addu_fwd_e: got %h want p0=4 p1=0", fwd_e_sel);
        end
        adv();
    endtask

    task automatic test_jal_jr();
        do_reset();
        set_d(31, 2, 0, 0, 3, 0, 3, 1'b0);
        adv();
        set_d(0, 0, 1, 31, 0, 0, 3, 1'b0);
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL jal_jr_stall: got %b want 1", stall);
        end
        adv();
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || fwd_d_sel[2:0] !== 3'd2) begin
            tests_failed++;
            $display("FAIL jal_jr_m_pc: got stall=%b sel=%0d want 0/2", stall, fwd_d_sel[2:0]);
        end
        adv();
        @(negedge clk);
        tests_run++;
        if (fwd_d_sel[2:0] !== 3'd5 || fwd_e_sel[2:0] !== 3'd5) begin
            tests_failed++;
            $display("FAIL jal_jr_w_pc: got d=%0d e=%0d want 5/5", fwd_d_sel[2:0], fwd_e_sel[2:0]);
        end
        adv();
    endtask

    task automatic test_zero_priority();
        do_reset();
        set_d(0, 0, 1, 0, 3, 0, 3, 1'b0);
        adv();
        set_d(0, 0, 1, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || fwd_d_sel !== '0 || fwd_e_sel !== '0) begin
            tests_failed++;
            $display("FAIL zero_reg: got stall=%b d=%h e=%h want 0", stall, fwd_d_sel, fwd_e_sel);
        end
        adv();
        set_d(4, 0, 1, 0, 3, 0, 3, 1'b0); adv();
        set_d(4, 2, 0, 0, 3, 0, 3, 1'b0); adv();
        nop(); adv();
        set_d(0, 0, 1, 4, 1, 4, 2, 1'b0);
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || fwd_d_sel !== {3'd2, 3'd2}) begin
            tests_failed++;
            $display("FAIL m_over_w: got stall=%b d=%h want 0 and both 2", stall, fwd_d_sel);
        end
        adv();
    endtask

    task automatic test_div_mfhi();
        int scnt, bcnt, fall_edge;
        do_reset();
        nop();
        d_md_use = 1'b1; e_md_start = 1'b1; e_md_div = 1'b1;
        scnt = 0; bcnt = 0; fall_edge = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (md_busy) bcnt++;
            if (k > 0 && !md_busy && fall_edge < 0) fall_edge = k;
            if (!stall) break;
            scnt++;
            adv();
            e_md_start = 1'b0;
        end
        tests_run++;
        if (scnt != 11) begin
            tests_failed++;
            $display("FAIL div_stall_len: got %0d want 11", scnt);
        end
        tests_run++;
        if (bcnt != 10 || fall_edge != 11) begin
            tests_failed++;
            $display("FAIL div_busy: got busy=%0d fall_after=%0d want 10/11", bcnt, fall_edge);
        end
        nop(); adv();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_d(1, 1, 2, 0, 3, 0, 3, 1'b0);
        e_md_start = 1'b1; e_md_div = 1'b1;
        adv();
        set_d(0, 0, 1, 1, 0, 0, 3, 1'b0);
        e_md_start = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b1 || md_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre: got stall=%b busy=%b want 1/1", stall, md_busy);
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({stall, md_busy, fwd_d_sel, fwd_e_sel} !== '0) begin
            tests_failed++;
            $display("FAIL mid_async: got stall=%b busy=%b d=%h e=%h want 0", stall, md_busy, fwd_d_sel, fwd_e_sel);
        end
        @(negedge clk);
        reset_n = 1'b1;
        set_d(0, 0, 1, 0, 3, 0, 3, 1'b1);
        #1;
        tests_run++;
        if (stall !== 1'b0 || md_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_mfhi: got stall=%b busy=%b want 0/0", stall, md_busy);
        end
        adv();
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || md_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_after_edge: got stall=%b busy=%b want 0/0", stall, md_busy);
        end
        nop(); adv();
    endtask

    task automatic test_random();
        int ws, nerr;
        do_reset();
        nerr = 0;
        for (int n = 0; n < 600; n++) begin
            ws = int'($urandom_range(0, 3));
            set_d(int'($urandom_range(0, 3)), ws,
                  (ws == 1) ? 2 : (ws == 2) ? 0 : 1,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0));
            model_eval();
            e_md_start = !exp_busy && ($urandom_range(0, 9) == 0);
            e_md_div   = $urandom_range(0, 1) == 1;
            @(negedge clk);
            model_eval();
            tests_run++;
            if (stall !== exp_stall || md_busy !== exp_busy ||
                fwd_d_sel !== exp_fd || fwd_e_sel !== exp_fe) begin
                tests_failed++;
                nerr++;
                if (nerr < 10)
                    $display("FAIL rand_cyc%0d: got stall=%b busy=%b d=%h e=%h want stall=%b busy=%b d=%h e=%h",
                             n, stall, md_busy, fwd_d_sel, fwd_e_sel, exp_stall, exp_busy, exp_fd, exp_fe);
            end
            adv();
        end
    endtask

    // Starting the MDU while it is busy is outside the legal protocol.
    always @(negedge clk)
        if (reset_n) assert (!(e_md_start && md_busy));

    initial begin
        test_reset();
        test_lw_beq();
        test_lw_addu();
        test_jal_jr();
        test_zero_priority();
        test_div_mfhi();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
